rca_response_checker: RTL
=========================

// Module: rca_response_checker
// PURPOSE
//  Receiving end of the adder test-vector interface: samples each applied vector {i0,i1,cin}
//  together with the adder's response {cout,o}, computes the golden sum, and tallies results.
//  Synthesizable; sits beside the ripple-carry adder (bench or on-chip BIST) and reports
//  pass/fail counts, a sticky error flag and the first failing vector.
// PARAMETERS
//  W         4   operand width of adder under check (sum is W bits + carry)
//  NUM_VECS  8   vectors checked before entering DONE
//  CW        $clog2(NUM_VECS+1)  derived localparam: counter width
// PORTS
//  clk         in   1     clock, all state on rising edge
//  reset       in   1     synchronous, active-high; one clock, reset sampled on rising clk edge
//  restart     in   1     sync clear of counts/flags, return to IDLE (no effect during reset)
//  vec_valid   in   1     i0/i1/cin/o/cout hold a settled vector+response this cycle
//  i0          in   W     operand A as applied to adder
//  i1          in   W     operand B
//  cin         in   1     carry in
//  o           in   W     adder sum output
//  cout        in   1     adder carry output
//  pass_count  out  CW    vectors matching golden
//  fail_count  out  CW    vectors mismatching golden
//  mismatch    out  1     one-cycle pulse per failing vector
//  fail_seen   out  1     sticky: any failure since reset/restart
//  first_fail  out  3W+2  {i0,i1,cin,cout,o} of first failing vector
//  first_exp   out  W+1   golden {cout,o} for first_fail
//  done        out  1     NUM_VECS vectors checked
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; all outputs and stage regs 0. restart: same clear; reset wins.
//  FSM: IDLE -vec_valid-> RUN; RUN -(checked==NUM_VECS)-> DONE; DONE -restart-> IDLE.
//   RUN also accepts vec_valid; IDLE's first valid is counted (IDLE only marks "none yet").
//  Stage 1 (edge E, vec_valid=1, state!=DONE): capture {i0,i1,cin,o,cout} into stage reg, stg_v=1.
//  Stage 2 (edge E+1, stg_v=1): exp = {1'b0,i0}+{1'b0,i1}+cin, W+1 bits, no truncation;
//   compare against {cout,o}. Match -> pass_count+1; else fail_count+1, mismatch=1 for that cycle.
//   Latency: counters/mismatch visible after edge E+1 (2 edges from sampling).
//  First failure only: load first_fail/first_exp and set fail_seen; later fails leave them.
//  DONE asserted at the same edge as the NUM_VECS-th count update; in DONE vec_valid ignored.
//  Back-to-back vec_valid every cycle fully supported (one vector per clock, no stall).
//  restart and vec_valid same cycle: restart wins, vector dropped, stage reg cleared.
//  restart while stage holds a vector: vector discarded, not counted.
//  Counters cannot exceed NUM_VECS (DONE blocks capture); pass_count+fail_count==checked.
//  Wrap-around: i0=i1=all-ones, cin=1 -> exp={1,all-ones}; carry must be checked, not dropped.
// STRUCTURE
//  rca_chk_defs.vh (shared include): state encodings ST_IDLE/ST_RUN/ST_DONE, default W,
//   NUM_VECS, vector field offsets for {i0,i1,cin} packing used by stimulus and checker.
//  Sub-module rca_golden_model: combinational W-bit a+b+cin -> {cout,sum}; reusable by bench.
//  Top: capture register, FSM, counters, first-fail capture regs.
// TESTING
//  T1 reset: hold reset 2 cycles with random inputs -> all outputs 0, state IDLE.
//  T2 correct adder, vectors 0000+0001+0, 0011+1000+1, 1111+0001+1, 0111+0111+0, 1010+0101+1,
//     0000+0000+1, 1111+1111+1, 0110+1001+0 back-to-back -> pass_count=8, fail_count=0, done=1
//     two edges after last valid, mismatch never high.
//  T3 inject fault (o=0101,cout=0 for 0011+0011+0, exp 00110) as 3rd vector -> mismatch pulse
//     1 cycle, fail_count=1, pass_count=7, first_fail={0011,0011,0,0,0101}, first_exp=00110.
//  T4 second fault after T3-style first -> fail_count=2, first_fail unchanged.
//  T5 carry check: 1111+1111+1 with cout forced 0, o=1111 -> fail (exp 11111).
//  T6 restart with vec_valid in same cycle mid-run (after 4 vectors) -> counts 0, IDLE,
//     vector not counted; 9th valid while DONE -> counts unchanged.

Source files
------------

// File: rtl/rca_response_checker_pkg.sv
// Shared definitions for the adder response checker and anything that
// drives it: default geometry, FSM state encodings and the bit layout used
// when an applied vector {i0,i1,cin} is packed into a single word.
package rca_response_checker_pkg;

    localparam int DEF_W        = 4;
    localparam int DEF_NUM_VECS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } chk_state_e;

    // Packed vector layout: cin in bit 0, i1 directly above it, i0 on top.
    localparam int VEC_CIN_BIT = 0;
    localparam int VEC_I1_LSB  = 1;

    function automatic int vec_i0_lsb(input int w);
        return 1 + w;
    endfunction

    function automatic int vec_width(input int w);
        return (2 * w) + 1;
    endfunction

endpackage

// File: rtl/rca_golden_model.sv
// Golden reference for a W-bit ripple-carry adder: {cout,sum} = a + b + cin.
// Ports:
//   a, b  in  W  operands
//   cin   in  1  carry in
//   sum   out W  low W bits of the result
//   cout  out 1  carry out of the top bit
module rca_golden_model
    import rca_response_checker_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total_s;

    // Add one bit wider than the operands so the top carry is never lost.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum     = total_s[W-1:0];
        cout    = total_s[W];
    end

endmodule

// File: rtl/rca_response_checker.sv
// Receiving end of the adder test-vector interface. Each valid cycle the
// applied vector and the adder's response are captured; one clock later the
// response is compared against the golden sum and the pass/fail tallies,
// sticky failure flag and first-failure snapshot are updated.
// Ports:
//   clk        in   1      clock, all state on the rising edge
//   reset      in   1      synchronous active-high reset
//   restart    in   1      synchronous clear back to IDLE
//   vec_valid  in   1      i0/i1/cin/o/cout carry a settled vector + response
//   i0, i1     in   W      operands as applied to the adder
//   cin        in   1      carry in as applied
//   o          in   W      adder sum output
//   cout       in   1      adder carry output
//   pass_count out  CW     vectors that matched the golden result
//   fail_count out  CW     vectors that did not match
//   mismatch   out  1      one-cycle pulse per failing vector
//   fail_seen  out  1      sticky: any failure since reset/restart
//   first_fail out  3W+2   {i0,i1,cin,cout,o} of the first failing vector
//   first_exp  out  W+1    golden {cout,o} for that vector
//   done       out  1      NUM_VECS vectors have been checked
module rca_response_checker
    import rca_response_checker_pkg::*;
#(
    parameter  int W        = DEF_W,
    parameter  int NUM_VECS = DEF_NUM_VECS,
    localparam int CW       = $clog2(NUM_VECS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            restart,
    input  logic            vec_valid,
    input  logic [W-1:0]    i0,
    input  logic [W-1:0]    i1,
    input  logic            cin,
    input  logic [W-1:0]    o,
    input  logic            cout,
    output logic [CW-1:0]   pass_count,
    output logic [CW-1:0]   fail_count,
    output logic            mismatch,
    output logic            fail_seen,
    output logic [3*W+1:0]  first_fail,
    output logic [W:0]      first_exp,
    output logic            done
);

    localparam int VW      = vec_width(W);
    localparam int I0_LSB  = vec_i0_lsb(W);
    localparam int I1_LSB  = VEC_I1_LSB;
    localparam int CIN_BIT = VEC_CIN_BIT;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0] NUM_VECS_C = CW'(NUM_VECS);

    chk_state_e      state_r;
    chk_state_e      next_state_s;

    logic            stg_v_r;
    logic [VW-1:0]   stg_vec_r;      // {i0,i1,cin}
    logic [W:0]      stg_rsp_r;      // {cout,o}

    logic [CW-1:0]   pass_count_r;
    logic [CW-1:0]   fail_count_r;
    logic            mismatch_r;
    logic            fail_seen_r;
    logic [3*W+1:0]  first_fail_r;
    logic [W:0]      first_exp_r;
    logic            done_r;

    logic [W-1:0]    exp_sum_s;
    logic            exp_cout_s;
    logic            match_s;
    logic [CW-1:0]   checked_s;
    logic            last_s;
    logic            capture_s;

    rca_golden_model #(
        .W(W)
    ) u_golden (
        .a    (stg_vec_r[I0_LSB +: W]),
        .b    (stg_vec_r[I1_LSB +: W]),
        .cin  (stg_vec_r[CIN_BIT]),
        .sum  (exp_sum_s),
        .cout (exp_cout_s)
    );

    // Compare, completion and capture-enable decisions for this cycle.
    always_comb begin
        match_s   = ({exp_cout_s, exp_sum_s} == stg_rsp_r);
        checked_s = pass_count_r + fail_count_r;
        // The staged vector is the final one: counting it completes the run.
        last_s    = stg_v_r && ((checked_s + CNT_ONE) == NUM_VECS_C);
        // Blocking capture on the completing edge keeps the tallies from
        // ever exceeding NUM_VECS, even with back-to-back valids.
        if (vec_valid && !restart && (state_r != ST_DONE) && !last_s) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Next-state logic; restart overrides every transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (vec_valid) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        if (restart) begin
            next_state_s = ST_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Stage 1: hold the sampled vector and response for one clock.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            stg_v_r   <= 1'b0;
            stg_vec_r <= {VW{1'b0}};
            stg_rsp_r <= {(W + 1){1'b0}};
        end else if (capture_s) begin
            stg_v_r   <= 1'b1;
            stg_vec_r <= {i0, i1, cin};
            stg_rsp_r <= {cout, o};
        end else begin
            stg_v_r   <= 1'b0;
        end
    end

    // Stage 2: tally the staged vector and snapshot the first failure.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            pass_count_r <= {CW{1'b0}};
            fail_count_r <= {CW{1'b0}};
            mismatch_r   <= 1'b0;
            fail_seen_r  <= 1'b0;
            first_fail_r <= {(3 * W + 2){1'b0}};
            first_exp_r  <= {(W + 1){1'b0}};
            done_r       <= 1'b0;
        end else begin
            mismatch_r <= 1'b0;
            done_r     <= (next_state_s == ST_DONE);
            if (stg_v_r) begin
                if (match_s) begin
                    pass_count_r <= pass_count_r + CNT_ONE;
                end else begin
                    fail_count_r <= fail_count_r + CNT_ONE;
                    mismatch_r   <= 1'b1;
                    if (!fail_seen_r) begin
                        fail_seen_r  <= 1'b1;
                        first_fail_r <= {stg_vec_r, stg_rsp_r};
                        first_exp_r  <= {exp_cout_s, exp_sum_s};
                    end else begin
                        fail_seen_r  <= fail_seen_r;
                    end
                end
            end else begin
                pass_count_r <= pass_count_r;
            end
        end
    end

    assign pass_count = pass_count_r;
    assign fail_count = fail_count_r;
    assign mismatch   = mismatch_r;
    assign fail_seen  = fail_seen_r;
    assign first_fail = first_fail_r;
    assign first_exp  = first_exp_r;
    assign done       = done_r;

endmodule
